// File: rtl/fifo_pkg.sv
// fifo_pkg: shared limits and sizing helpers for the fifo_peek family
package fifo_pkg;
  localparam int FIFO_MAX_ADDR_EXP = 16;
  localparam int FIFO_MAX_PEEK = 8;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int count_width(input int addr_exp);
    return addr_exp + 1;
  endfunction
endpackage

// File: rtl/fifo_peek_if.sv
// fifo_peek_if: user-side handshake and status bundle of fifo_peek
interface fifo_peek_if
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SPACE_EXP = 4,
  parameter int PEEK_DEPTH = 2
) ();
  logic flush;
  logic write_to_fifo;
  logic read_from_fifo;
  logic [DATA_SIZE-1:0] write_data_in;
  logic [DATA_SIZE-1:0] read_data_out;
  logic [PEEK_DEPTH*DATA_SIZE-1:0] peek_data;
  logic [count_width(ADDR_SPACE_EXP)-1:0] count;
  logic empty;
  logic full;
  logic almost_empty;
  logic almost_full;
  logic overflow;
  logic underflow;
  modport master (
    output flush, write_to_fifo, read_from_fifo, write_data_in,
    input read_data_out, peek_data, count, empty, full, almost_empty, almost_full, overflow, underflow
  );
  modport slave (
    input flush, write_to_fifo, read_from_fifo, write_data_in,
    output read_data_out, peek_data, count, empty, full, almost_empty, almost_full, overflow, underflow
  );
endinterface

// File: rtl/fifo_peek_history.sv
// fifo_peek_history: shift register of the most recently written words, slot 0 newest
module fifo_peek_history #(
  parameter int DATA_SIZE = 8,
  parameter int PEEK_DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic shift_en,
  input  logic [DATA_SIZE-1:0] din,
  output logic [PEEK_DEPTH*DATA_SIZE-1:0] hist
);
  localparam int W = PEEK_DEPTH * DATA_SIZE;
  always_ff @(posedge clk) begin
    if (reset) hist <= '0;
    else if (shift_en) hist <= (hist << DATA_SIZE) | W'(din);
  end
endmodule

// File: rtl/fifo_peek.sv
// fifo_peek: first-word-fall-through FIFO with count, level flags, sticky errors and write history
module fifo_peek
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SPACE_EXP = 4,
  parameter int PEEK_DEPTH = 2,
  parameter int AF_LEVEL = (1 << ADDR_SPACE_EXP) - 2,
  parameter int AE_LEVEL = 2
) (
  input logic clk,
  input logic reset,
  fifo_peek_if.slave bus
);
  localparam int D = 1 << ADDR_SPACE_EXP;
  localparam int CW = count_width(ADDR_SPACE_EXP);
  localparam logic [CW-1:0] FULL_C = CW'(D);
  localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C = CW'(AE_LEVEL);
  if (ADDR_SPACE_EXP < 1 || ADDR_SPACE_EXP > FIFO_MAX_ADDR_EXP || PEEK_DEPTH < 1 ||
      PEEK_DEPTH > FIFO_MAX_PEEK || DATA_SIZE < 1 || AF_LEVEL < 0 || AF_LEVEL > D ||
      AE_LEVEL < 0 || AE_LEVEL > D) begin : g_bad_param
    $error("fifo_peek: illegal parameter set");
  end
  logic [DATA_SIZE-1:0] r_mem [D];
  logic [ADDR_SPACE_EXP-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic r_ovf, r_udf;
  logic w_push, w_pop, w_empty, w_full, w_clr;
  // a full FIFO still accepts a write when a read frees the head slot in the same cycle
  always_comb begin
    w_clr = reset | bus.flush;
    w_empty = r_count == '0;
    w_full = r_count == FULL_C;
    w_push = ~w_clr & bus.write_to_fifo & (~w_full | bus.read_from_fifo);
    w_pop = ~w_clr & bus.read_from_fifo & ~w_empty;
  end
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + ADDR_SPACE_EXP'(w_push);
      r_rd_ptr <= r_rd_ptr + ADDR_SPACE_EXP'(w_pop);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_ovf <= r_ovf | (bus.write_to_fifo & ~w_push);
      r_udf <= r_udf | (bus.read_from_fifo & ~w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.write_data_in;
  end
  fifo_peek_history #(.DATA_SIZE(DATA_SIZE), .PEEK_DEPTH(PEEK_DEPTH)) u_hist (
    .clk(clk),
    .reset(reset),
    .shift_en(w_push),
    .din(bus.write_data_in),
    .hist(bus.peek_data)
  );
  assign bus.read_data_out = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.count = r_count;
  assign bus.empty = w_empty;
  assign bus.full = w_full;
  assign bus.almost_empty = r_count <= AE_C;
  assign bus.almost_full = r_count >= AF_C;
  assign bus.overflow = r_ovf;
  assign bus.underflow = r_udf;
endmodule

// File: tb/tb_fifo_peek.sv
// tb_fifo_peek: table vectors plus scoreboard-checked sequences for fifo_peek (D=16, peek depth 2)
module tb_fifo_peek;
  logic clk, reset;
  int n_cmp = 0, n_err = 0;
  int m_count = 0;
  logic m_ovf = 0, m_udf = 0;
  logic [15:0] m_peek = '0;
  logic [7:0] q[$];
  typedef struct {
    logic wr, rd;
    logic [7:0] din;
    int cnt;
    logic ae;
    logic [7:0] head, p0, p1;
    logic udf;
  } vec_t;
  vec_t tbl[8];
  fifo_peek_if #(.DATA_SIZE(8), .ADDR_SPACE_EXP(4), .PEEK_DEPTH(2)) bus ();
  fifo_peek #(.DATA_SIZE(8), .ADDR_SPACE_EXP(4), .PEEK_DEPTH(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step(input logic wr, input logic rd, input logic [7:0] din, input logic fl, input logic rs);
    logic push_ok, pop_ok;
    logic [7:0] exp_d;
    @(negedge clk);
    bus.write_to_fifo = wr;
    bus.read_from_fifo = rd;
    bus.write_data_in = din;
    bus.flush = fl;
    reset = rs;
    #1;
    push_ok = !rs && !fl && wr && (m_count != 16 || rd);
    pop_ok = !rs && !fl && rd && m_count != 0;
    if (pop_ok) begin
      exp_d = q.pop_front();
      check("pop_data", {24'h0, bus.read_data_out}, {24'h0, exp_d});
    end
    @(posedge clk);
    #1;
    if (rs || fl) begin
      q.delete();
      m_ovf = 0;
      m_udf = 0;
      if (rs) m_peek = '0;
    end else begin
      if (push_ok) begin
        q.push_back(din);
        m_peek = {m_peek[7:0], din};
      end
      m_ovf = m_ovf | (wr & !push_ok);
      m_udf = m_udf | (rd & !pop_ok);
    end
    m_count = q.size();
    check("count", 32'(bus.count), 32'(m_count));
    check("empty", 32'(bus.empty), 32'(m_count == 0));
    check("full", 32'(bus.full), 32'(m_count == 16));
    check("almost_empty", 32'(bus.almost_empty), 32'(m_count <= 2));
    check("almost_full", 32'(bus.almost_full), 32'(m_count >= 14));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    check("underflow", 32'(bus.underflow), 32'(m_udf));
    check("peek", 32'(bus.peek_data), 32'(m_peek));
    check("head", 32'(bus.read_data_out), m_count != 0 ? 32'(q[0]) : 32'h0);
  endtask
  task automatic fill_to_five_with_overflow();
    for (int i = 0; i < 16; i++) step(1, 0, 8'(i), 0, 0);
    step(1, 0, 8'hFF, 0, 0);
    for (int i = 0; i < 11; i++) step(0, 1, 0, 0, 0);
    check("pre_count5", 32'(bus.count), 32'd5);
    check("pre_ovf", 32'(bus.overflow), 32'd1);
  endtask
  initial begin
    bus.flush = 0;
    bus.write_to_fifo = 0;
    bus.read_from_fifo = 0;
    bus.write_data_in = 0;
    reset = 1;
    tbl[0] = '{1'b1, 1'b0, 8'hA1, 1, 1'b1, 8'hA1, 8'hA1, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 8'hB2, 2, 1'b1, 8'hA1, 8'hB2, 8'hA1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 8'hC3, 3, 1'b0, 8'hA1, 8'hC3, 8'hB2, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 8'h00, 2, 1'b1, 8'hB2, 8'hC3, 8'hB2, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 8'h00, 1, 1'b1, 8'hC3, 8'hC3, 8'hB2, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 8'h00, 8'hC3, 8'hB2, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 8'h00, 8'hC3, 8'hB2, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 8'h3C, 1, 1'b1, 8'h3C, 8'h3C, 8'hC3, 1'b1};
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_af", 32'(bus.almost_full), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].din, 0, 0);
      check($sformatf("t%0d_count", i), 32'(bus.count), 32'(tbl[i].cnt));
      check($sformatf("t%0d_ae", i), 32'(bus.almost_empty), 32'(tbl[i].ae));
      check($sformatf("t%0d_head", i), 32'(bus.read_data_out), 32'(tbl[i].head));
      check($sformatf("t%0d_p0", i), 32'(bus.peek_data[7:0]), 32'(tbl[i].p0));
      check($sformatf("t%0d_p1", i), 32'(bus.peek_data[15:8]), 32'(tbl[i].p1));
      check($sformatf("t%0d_udf", i), 32'(bus.underflow), 32'(tbl[i].udf));
    end
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 0, 8'(i), 0, 0);
    step(1, 0, 8'hFF, 0, 0);
    check("ovf_full", 32'(bus.full), 32'd1);
    check("ovf_count", 32'(bus.count), 32'd16);
    check("ovf_flag", 32'(bus.overflow), 32'd1);
    check("ovf_p0", 32'(bus.peek_data[7:0]), 32'h0F);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 0);
    check("drain_empty", 32'(bus.empty), 32'd1);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 0, 8'(i), 0, 0);
    step(1, 1, 8'h55, 0, 0);
    check("rw_full_count", 32'(bus.count), 32'd16);
    check("rw_full_head", 32'(bus.read_data_out), 32'h01);
    check("rw_full_p0", 32'(bus.peek_data[7:0]), 32'h55);
    check("rw_full_ovf", 32'(bus.overflow), 32'd0);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 8'($urandom), 0, 0);
      check("wrap_count1", 32'(bus.count), 32'd1);
      step(0, 1, 0, 0, 0);
    end
    step(0, 0, 0, 0, 1);
    fill_to_five_with_overflow();
    step(1, 0, 8'h77, 1, 0);
    check("flush_count", 32'(bus.count), 32'd0);
    check("flush_empty", 32'(bus.empty), 32'd1);
    check("flush_ovf", 32'(bus.overflow), 32'd0);
    check("flush_peek", 32'(bus.peek_data), 32'h0E0F);
    fill_to_five_with_overflow();
    step(1, 0, 8'h77, 0, 1);
    check("reset_count", 32'(bus.count), 32'd0);
    check("reset_ovf", 32'(bus.overflow), 32'd0);
    check("reset_peek", 32'(bus.peek_data), 32'h0);
    step(0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
